// File: rtl/nios_switch_pkg.sv
// nios_switch_pkg
// Shared constants for the Nios switch-input controller: Avalon-MM register
// word addresses and the default build parameters.
package nios_switch_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;   // debounced switch levels (RO)
    localparam logic [1:0] ADDR_RSVD = 2'd1;   // reserved, reads 0
    localparam logic [1:0] ADDR_MASK = 2'd2;   // interrupt mask (RW)
    localparam logic [1:0] ADDR_EDGE = 2'd3;   // edge capture (write-1-to-clear)

    localparam int DEFAULT_WIDTH           = 10;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;

endpackage

// File: rtl/nios_switch_debounce.sv
// nios_switch_debounce
// Per-bit 2-flop synchronizer followed by a two-sample debouncer. On each
// shared tick the synchronized level is captured into a sample register.
// A debounced bit follows the synchronized bit only when that bit matched the
// previous tick's sample, so a level must hold across two ticks to pass.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   tick_i       one-cycle debounce sample strobe from the top level
//   in_i         raw asynchronous switch levels
//   debounced_o  debounced switch levels
module nios_switch_debounce
    import nios_switch_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] debounced_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sample_q;
    logic [WIDTH-1:0] sample_d;
    logic [WIDTH-1:0] deb_q;
    logic [WIDTH-1:0] deb_d;

    // Each bit is debounced independently: a bit whose sync value equals its
    // own previous sample is stable and may load; other bits hold.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_comb begin
                sample_d[gi] = sample_q[gi];
                deb_d[gi]    = deb_q[gi];
                if (tick_i) begin
                    sample_d[gi] = sync_q[gi];
                    if (sync_q[gi] == sample_q[gi]) begin
                        deb_d[gi] = sync_q[gi];
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q   <= '0;
            sync_q   <= '0;
            sample_q <= '0;
            deb_q    <= '0;
        end else begin
            meta_q   <= in_i;
            sync_q   <= meta_q;
            sample_q <= sample_d;
            deb_q    <= deb_d;
        end
    end

    assign debounced_o = deb_q;

endmodule

// File: rtl/nios_switch_ctrl.sv
// nios_switch_ctrl
// Avalon-MM switch-input peripheral: debounced switch levels, optional
// per-bit edge capture with interrupt mask and a level interrupt.
//
// Optional feature macro: NIOS_SWITCH_EDGE_IRQ_EN compiles in the mask and
// edge-capture registers and the irq logic. Without it, addresses 2 and 3
// read 0, writes are ignored and irq stays 0.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   address        Avalon-MM word address (0 data, 1 rsvd, 2 mask, 3 edge)
//   chipselect     slave select; write_n active-low write strobe
//   writedata      write data
//   readdata       registered read data, 1-cycle latency, not gated by select
//   in_port        raw switch levels
//   irq            registered level interrupt
module nios_switch_ctrl
    import nios_switch_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0]    tick_cnt_q;
    logic [CW-1:0]    tick_cnt_d;
    logic             tick;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] mask_rd;
    logic [WIDTH-1:0] edge_rd;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             irq_q;
    logic             irq_d;
    logic             unused_bits;

    // Select and data are only consumed when the edge feature is built in.
    assign unused_bits = ^{chipselect, write_n, writedata};

    assign tick = (tick_cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    always_comb begin
        tick_cnt_d = tick_cnt_q + CW'(1);
        if (tick) begin
            tick_cnt_d = '0;
        end
    end

    nios_switch_debounce #(
        .WIDTH (WIDTH)
    ) u_debounce (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick_i      (tick),
        .in_i        (in_port),
        .debounced_o (debounced)
    );

`ifdef NIOS_SWITCH_EDGE_IRQ_EN
    logic             wr_en;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] edge_d;
    logic [WIDTH-1:0] deb_prev_q;
    logic [1:0]       startup_q;
    logic [1:0]       startup_d;
    logic             armed;

    assign wr_en = chipselect & ~write_n;

    // Counts ticks since reset, saturating at 3. A debounced change can first
    // occur on tick 2 (sample starts at 0); changes on ticks 1-2 are the
    // power-up settle and must not raise edges, so detection arms from tick 3.
    assign armed = (startup_q == 2'd3);

    always_comb begin
        startup_d = startup_q;
        if (tick && !armed) begin
            startup_d = startup_q + 2'd1;
        end

        mask_d = mask_q;
        if (wr_en && address == ADDR_MASK) begin
            mask_d = writedata[WIDTH-1:0];
        end

        // Clear first, then set, so a coincident edge wins.
        edge_d = edge_q;
        if (wr_en && address == ADDR_EDGE) begin
            edge_d = edge_d & ~writedata[WIDTH-1:0];
        end
        if (armed) begin
            edge_d = edge_d | (debounced ^ deb_prev_q);
        end

        irq_d = |(edge_q & mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q     <= '0;
            edge_q     <= '0;
            deb_prev_q <= '0;
            startup_q  <= '0;
        end else begin
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            deb_prev_q <= debounced;
            startup_q  <= startup_d;
        end
    end

    assign mask_rd = mask_q;
    assign edge_rd = edge_q;
`else
    assign mask_rd = '0;
    assign edge_rd = '0;
    assign irq_d   = 1'b0;
`endif

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA: readdata_d[WIDTH-1:0] = debounced;
            ADDR_RSVD: readdata_d = '0;
            ADDR_MASK: readdata_d[WIDTH-1:0] = mask_rd;
            ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_rd;
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios_switch_ctrl.sv
// tb_nios_switch_ctrl
// Directed scenarios plus randomized traffic for nios_switch_ctrl
// (WIDTH=10, DEBOUNCE_CYCLES=4). A behavioural model tracks in_port history,
// tick instants and the two-tick stability rule; readdata and irq are compared
// with it after every clock. Literal expectations pin key scenarios.
// Honours NIOS_SWITCH_EDGE_IRQ_EN to select the expected feature set.
module tb_nios_switch_ctrl;

    localparam int W = 10;
    localparam int D = 4;
`ifdef NIOS_SWITCH_EDGE_IRQ_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port = '0;
    logic          irq;

    int n_cmp = 0;
    int n_bad = 0;

    nios_switch_ctrl #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int           m_e;        // clock edges since reset release
    int           m_ticks;    // ticks since reset release
    logic [W-1:0] in_at_1;    // in_port seen at the previous edge
    logic [W-1:0] in_at_2;    // in_port seen two edges ago (= sync level now)
    logic [W-1:0] m_sample, m_deb, m_mask, m_edge, m_chg;
    logic         m_chg_ok;   // last change happened on tick 3 or later
    logic [31:0]  m_rd;
    logic         m_irq;
    logic [W-1:0] cur_in;

    task automatic model_reset();
        m_e = 0; m_ticks = 0; in_at_1 = '0; in_at_2 = '0;
        m_sample = '0; m_deb = '0; m_mask = '0; m_edge = '0; m_chg = '0;
        m_chg_ok = 1'b0; m_rd = '0; m_irq = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
        $display("pin %-12s readdata/irq value %08h (expected %08h)", name, act, exp);
    endtask

    // One bus cycle: drive after a falling edge, advance the model across the
    // rising edge, compare on the next falling edge.
    task automatic step(input logic [1:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input logic [W-1:0] inp);
        logic [W-1:0] sync_lvl, n_sample, n_deb, n_edge, n_mask;
        logic         tick, wr;
        int           n_ticks;
        address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = inp;

        tick = ((m_e + 1) % D) == 0;
        sync_lvl = in_at_2;
        n_sample = m_sample; n_deb = m_deb; n_ticks = m_ticks;
        if (tick) begin
            n_ticks = m_ticks + 1;
            n_sample = sync_lvl;
            for (int b = 0; b < W; b++)
                if (sync_lvl[b] == m_sample[b]) n_deb[b] = sync_lvl[b];
        end
        wr = cs && !wn;
        n_mask = (wr && a == 2'd2) ? wd[W-1:0] : m_mask;
        n_edge = m_edge;
        if (wr && a == 2'd3) n_edge = n_edge & ~wd[W-1:0];
        if (m_chg_ok) n_edge = n_edge | m_chg;
        if (!FEAT) begin n_mask = '0; n_edge = '0; end

        case (a)
            2'd0: m_rd = {22'b0, m_deb};
            2'd2: m_rd = {22'b0, m_mask};
            2'd3: m_rd = {22'b0, m_edge};
            default: m_rd = '0;
        endcase
        m_irq = FEAT && ((m_edge & m_mask) != '0);

        @(posedge clk);
        m_chg = n_deb ^ m_deb;
        m_chg_ok = n_ticks >= 3;
        m_e++; m_ticks = n_ticks;
        m_sample = n_sample; m_deb = n_deb; m_mask = n_mask; m_edge = n_edge;
        in_at_2 = in_at_1; in_at_1 = inp;

        @(negedge clk);
        check("model_rd", readdata, m_rd);
        check("model_irq", {31'b0, irq}, {31'b0, m_irq});
    endtask

    task automatic rd(input logic [1:0] a);
        step(a, 1'b1, 1'b1, 32'h0, cur_in);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        step(a, 1'b1, 1'b0, d, cur_in);
        $display("write addr %0d data %08h", a, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("async_rst_rd", readdata, 32'h0);
        check("async_rst_irq", {31'b0, irq}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] gmask;
        int           glitch_left;
        bit           hit;
        cur_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        pin("reset_rd", readdata, 32'h0);
        pin("reset_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;

        // Let the power-up settle ticks pass, then read address 0.
        repeat (10) rd(2'd0);
        pin("data_idle", readdata, 32'h0);
        pin("irq_idle", {31'b0, irq}, 32'h0);

        // All switches high for 12 cycles.
        cur_in = 10'h3FF;
        repeat (12) rd(2'd0);
        pin("data_all", readdata, 32'h3FF);
        rd(2'd3);
        pin("edge_all", readdata, FEAT ? 32'h3FF : 32'h0);
        pin("irq_nomask", {31'b0, irq}, 32'h0);

        // Back to 0, clear edges, then a 3-cycle glitch on bit 0.
        cur_in = '0;
        repeat (16) rd(2'd0);
        wr(2'd3, 32'h3FF);
        repeat (2) rd(2'd0);
        cur_in = 10'h001;
        repeat (3) rd(2'd0);
        cur_in = '0;
        repeat (12) rd(2'd0);
        pin("glitch_data", readdata, 32'h0);
        rd(2'd3);
        pin("glitch_edge", readdata, 32'h0);

        // Masked rising edge on bit 0 raises irq; clearing it drops irq.
        wr(2'd2, 32'h001);
        cur_in = 10'h001;
        repeat (14) rd(2'd3);
        pin("edge_b0", readdata, FEAT ? 32'h1 : 32'h0);
        pin("irq_b0", {31'b0, irq}, FEAT ? 32'h1 : 32'h0);
        wr(2'd3, 32'h001);
        rd(2'd3);
        pin("edge_clr", readdata, 32'h0);
        pin("irq_clr", {31'b0, irq}, 32'h0);

        // Clear of bit 2 in the very cycle its new edge is being set.
        cur_in = 10'h005;
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            if (m_chg_ok && m_chg[2]) begin
                wr(2'd3, 32'h004);
                hit = 1'b1;
            end else begin
                rd(2'd3);
            end
        end
        check("b2_collide_seen", {31'b0, hit}, 32'h1);
        rd(2'd3);
        pin("edge_b2_kept", readdata & 32'h4, FEAT ? 32'h4 : 32'h0);

        // Mask write and readback.
        wr(2'd2, 32'h3FF);
        rd(2'd2);
        pin("mask_rd", readdata, FEAT ? 32'h3FF : 32'h0);

        // Randomized traffic with input glitches and one mid-run reset.
        glitch_left = 0;
        gmask = '0;
        for (int c = 0; c < 1500; c++) begin
            logic [1:0]  a;
            logic        cs, wn;
            logic [31:0] wd;
            logic [W-1:0] drive;
            if (c == 700) do_reset();
            if (glitch_left > 0) begin
                glitch_left--;
            end else if ($urandom_range(0, 99) < 6) begin
                cur_in = W'($urandom);
            end else if ($urandom_range(0, 99) < 5) begin
                gmask = W'(1) << $urandom_range(0, W - 1);
                glitch_left = $urandom_range(1, 3);
            end
            drive = (glitch_left > 0) ? (cur_in ^ gmask) : cur_in;
            a  = 2'($urandom_range(0, 3));
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 4) != 0);
            wd = $urandom;
            step(a, cs, wn, wd, drive);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nios_switch_ctrl.md
NIOS_SWITCH_CTRL -- requirements
Module: nios_switch_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 10, number of switch inputs (1..32).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000, clk cycles per debounce sample tick (>=2).
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port address  input  2  Avalon-MM word address.
REQ-006 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-007 SHALL have port write_n  input  1  Avalon-MM write strobe, active-low.
REQ-008 SHALL have port writedata  input  32  Avalon-MM write data.
REQ-009 SHALL have port readdata  output  32  registered Avalon-MM read data.
REQ-010 SHALL have port in_port  input  WIDTH  raw asynchronous switch levels.
REQ-011 SHALL have port irq  output  1  level interrupt request, active-high.

Function
REQ-012 SHALL pass in_port through a 2-flop synchronizer per bit; the second flop is the sync value.
REQ-013 SHALL run a tick counter 0..DEBOUNCE_CYCLES-1, wrapping to 0, and assert a one-cycle tick when the count equals DEBOUNCE_CYCLES-1.
REQ-014 SHALL, on each tick, capture the sync value into a per-bit sample register.
REQ-015 SHALL, on a tick where sync equals sample, load sync into the debounced register; otherwise the debounced register holds.
REQ-016 SHALL therefore update a debounced bit only after its sync value has been stable across two consecutive ticks; shorter glitches are ignored.
REQ-017 SHALL map registers: 0 = debounced data (RO), 1 = reads 0, 2 = interrupt mask (RW, WIDTH bits), 3 = edge capture (read, write-1-to-clear).
REQ-018 SHALL load readdata every clock with the zero-extended register selected by address, giving 1-cycle read latency independent of chipselect.
REQ-019 SHALL accept a write when chipselect=1 and write_n=0; writes to addresses 0 and 1 are ignored.
REQ-020 SHALL set edge capture bit i when debounced bit i changes in either direction, one cycle after the debounced update.
REQ-021 SHALL give set priority over clear when an edge and a write-1-to-clear hit the same bit in the same cycle.
REQ-022 SHALL drive irq registered as the OR of (edge capture AND mask), one cycle after either operand changes.

Reset
REQ-023 SHALL clear synchronizer, sample, debounced, tick counter, mask, edge capture, readdata and irq to 0 when reset_n is low.
REQ-024 SHALL abandon any in-progress debounce on reset; after release the tick counter restarts from 0.
REQ-025 SHALL not set edge capture for a debounced transition away from the reset value of 0 that completes within the first two ticks after reset release.

Configuration
REQ-026 SHALL use macro NIOS_SWITCH_EDGE_IRQ_EN to compile in the edge-capture/interrupt feature.
REQ-027 SHALL, with the macro defined, implement REQ-020..REQ-022 and registers 2 and 3 as specified.
REQ-028 SHALL, without the macro, omit mask and edge-capture state, read 0 at addresses 2 and 3, ignore writes to them, and tie irq to 0.

Structure
REQ-029 SHALL place register address constants (ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3) and the default WIDTH and DEBOUNCE_CYCLES in package nios_switch_pkg.
REQ-030 SHALL implement synchronizer, sample and debounced registers as sub-module nios_switch_debounce, driven by the shared tick from the top level.

Verification (DEBOUNCE_CYCLES=4, WIDTH=10)
REQ-031 SHALL cover: reset, then read address 0 -> readdata=0x000 and irq=0.
REQ-032 SHALL cover: in_port=0x3FF held 12 cycles, then read address 0 -> readdata=0x3FF; edge capture reads 0x3FF and irq stays 0 with mask=0.
REQ-033 SHALL cover: bit 0 pulsed high for 3 cycles between ticks -> address 0 stays 0x000 and edge capture stays 0.
REQ-034 SHALL cover: mask=0x001, bit 0 rises and holds -> irq=1 one cycle after edge bit 0 sets; writing 0x001 to address 3 -> edge capture reads 0x000 and irq=0 next cycle.
REQ-035 SHALL cover: write-1-to-clear of bit 2 coinciding with a new bit 2 edge -> bit 2 remains set.
REQ-036 SHALL cover: build without NIOS_SWITCH_EDGE_IRQ_EN, write 0x3FF to address 2 -> addresses 2 and 3 read 0 and irq stays 0 while inputs toggle.
